// File: rtl/seq_restoring_divider.sv
// Iterative unsigned radix-2 restoring divider.
// A start pulse captures a dividend/divisor pair. The divider then runs one trial
// subtraction per clock and returns the quotient and remainder with a one-cycle
// done pulse. A zero divisor short-circuits to a flagged result in one cycle.
module seq_restoring_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DIVZ
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [N-1:0]  q_reg;      // dividend shifts out, quotient bits shift in
    logic [N-1:0]  d_reg;
    logic [N-1:0]  r_reg;      // partial remainder, always < divisor between steps
    logic [N:0]    r_shift;    // shifted remainder needs one extra bit before the trial
    logic [N:0]    trial;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;
    logic          accept;
    logic          last_iter;
    logic          div_zero;

    assign ready     = (state == IDLE) || (state == DONE);
    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign accept    = ready & start;
    assign last_iter = (count == CW'(N - 1));
    assign div_zero  = (Divisor == '0);

    // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if non-negative.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        r_next  = r_reg;
        q_next  = q_reg;
        r_shift = {r_reg, q_reg[N-1]};
        trial   = r_shift - {1'b0, d_reg};
        if (!trial[N]) begin
            r_next = trial[N-1:0];
            q_next = {q_reg[N-2:0], 1'b1};
        end else begin
            r_next = r_shift[N-1:0];
            q_next = {q_reg[N-2:0], 1'b0};
        end
    end

    // Control FSM: IDLE -> CALC -> DONE; an accept in DONE restarts without passing IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count <= '0;
                        state <= div_zero ? DONE : CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (last_iter) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and working registers: load on accept, advance one step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
        end else if (accept) begin
            q_reg <= Dividend;
            d_reg <= Divisor;
            r_reg <= '0;
        end else if (busy) begin
            q_reg <= q_next;
            r_reg <= r_next;
        end
    end

    // Result registers: updated only when a result completes, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Quotient  <= '0;
            Remainder <= '0;
            DIVZ      <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                Quotient  <= '1;
                Remainder <= Dividend;
                DIVZ      <= 1'b1;
            end else begin
                DIVZ      <= 1'b0;
            end
        end else if (busy && last_iter) begin
            Quotient  <= q_next;
            Remainder <= r_next;
        end
    end

endmodule
